// File: rtl/hdmi_ddc_edid_slave.sv
// hdmi_ddc_edid_slave: I2C (DDC) responder presenting the sink EDID at DEV_ADDR, fed from a sync ROM port.
// Ports: clk/reset (sync, active-high); scl_i/sda_i async pad inputs; sda_oen open-drain enable (0 = pull low);
//        rom_addr/rom_data EDID byte fetch port (data valid 1 clk after address); busy while addressed
//        (START..STOP); rd_strobe 1-clk pulse per byte shifted out.
// Optional build macro DDC_SEGMENT_EN adds the E-DDC segment pointer at SEG_ADDR (ADDR_W >= 9 required).
module hdmi_ddc_edid_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter logic [6:0] SEG_ADDR   = 7'h30,
  parameter int         FILTER_LEN = 3,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oen,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              rd_strobe
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  typedef enum logic [3:0] {IDLE, ADDR, AACK, WOFS, WDATA, WACK, READ, RACK, SEG} st_t;
  logic [1:0] s1_q, s2_q, p_q, filt;
  st_t        st_q;
  logic [3:0] bit_q;
  logic [7:0] sr_q, off_q;
  logic       rw_q, nack_q, seg_sel_q;
  logic       scl_f, sda_f, scl_rise, scl_fall, start, stop;
  always_ff @(posedge clk) begin
    s1_q <= reset ? 2'b11 : {scl_i, sda_i};
    s2_q <= reset ? 2'b11 : s1_q;
    p_q  <= reset ? 2'b11 : filt;
  end
  // a level is accepted only after FILTER_LEN consecutive clks of disagreement with the filtered value
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [CW-1:0] cnt_q;
    logic          f_q;
    always_ff @(posedge clk)
      if (reset) begin
        cnt_q <= '0;
        f_q   <= 1'b1;
      end else if (s2_q[g] == f_q) cnt_q <= '0;
      else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q <= '0;
        f_q   <= s2_q[g];
      end else cnt_q <= cnt_q + 1'b1;
    assign filt[g] = f_q;
  end
  assign scl_f    = filt[1];
  assign sda_f    = filt[0];
  assign scl_rise = scl_f & ~p_q[1];
  assign scl_fall = ~scl_f & p_q[1];
  assign start    = scl_f & p_q[1] & p_q[0] & ~sda_f;
  assign stop     = scl_f & p_q[1] & ~p_q[0] & sda_f;
`ifdef DDC_SEGMENT_EN
  logic [ADDR_W-9:0] seg_q;
  assign rom_addr = {seg_q, off_q};
`else
  assign rom_addr = ADDR_W'(off_q);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      bit_q     <= '0;
      sr_q      <= '0;
      off_q     <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      seg_sel_q <= 1'b0;
      sda_oen   <= 1'b1;
      busy      <= 1'b0;
      rd_strobe <= 1'b0;
`ifdef DDC_SEGMENT_EN
      seg_q     <= '0;
`endif
    end else begin
      rd_strobe <= 1'b0;
      // START/STOP take priority over any SCL edge seen in the same clk
      if (start) begin
        st_q    <= ADDR;
        bit_q   <= '0;
        sda_oen <= 1'b1;
      end else if (stop) begin
        st_q    <= IDLE;
        sda_oen <= 1'b1;
        busy    <= 1'b0;
`ifdef DDC_SEGMENT_EN
        seg_q   <= '0;
`endif
      end else if (scl_rise) begin
        case (st_q)
          ADDR, WOFS, WDATA, SEG: begin
            sr_q  <= {sr_q[6:0], sda_f};
            bit_q <= bit_q + 4'd1;
          end
          AACK: if (rw_q) sr_q <= rom_data;
          // the next byte is loaded speculatively; nack_q decides whether it is sent
          RACK: begin
            nack_q <= sda_f;
            sr_q   <= rom_data;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (st_q)
          ADDR: if (bit_q == 4'd8) begin
            if (sr_q[7:1] == DEV_ADDR) begin
              sda_oen   <= 1'b0;
              busy      <= 1'b1;
              rw_q      <= sr_q[0];
              seg_sel_q <= 1'b0;
              st_q      <= AACK;
            end
`ifdef DDC_SEGMENT_EN
            else if (sr_q == {SEG_ADDR, 1'b0}) begin
              sda_oen   <= 1'b0;
              busy      <= 1'b1;
              rw_q      <= 1'b0;
              seg_sel_q <= 1'b1;
              st_q      <= AACK;
            end
`endif
            else begin
              busy <= 1'b0;
              st_q <= IDLE;
            end
          end
          AACK: if (rw_q) begin
            sda_oen <= sr_q[7];
            sr_q    <= {sr_q[6:0], 1'b0};
            bit_q   <= 4'd1;
            st_q    <= READ;
          end else begin
            sda_oen <= 1'b1;
            bit_q   <= '0;
            st_q    <= seg_sel_q ? SEG : WOFS;
          end
          WOFS: if (bit_q == 4'd8) begin
            off_q   <= sr_q;
            sda_oen <= 1'b0;
            st_q    <= WACK;
          end
          WDATA: if (bit_q == 4'd8) begin
            off_q   <= off_q + 8'd1;
            sda_oen <= 1'b0;
            st_q    <= WACK;
          end
          SEG: if (bit_q == 4'd8) begin
`ifdef DDC_SEGMENT_EN
            seg_q   <= sr_q[ADDR_W-9:0];
`endif
            sda_oen <= 1'b0;
            st_q    <= WACK;
          end
          WACK: begin
            sda_oen <= 1'b1;
            bit_q   <= '0;
            st_q    <= seg_sel_q ? IDLE : WDATA;
          end
          READ: if (bit_q == 4'd8) begin
            sda_oen   <= 1'b1;
            off_q     <= off_q + 8'd1;
            rd_strobe <= 1'b1;
            st_q      <= RACK;
          end else begin
            sda_oen <= sr_q[7];
            sr_q    <= {sr_q[6:0], 1'b0};
            bit_q   <= bit_q + 4'd1;
          end
          RACK: if (nack_q) st_q <= IDLE;
          else begin
            sda_oen <= sr_q[7];
            sr_q    <= {sr_q[6:0], 1'b0};
            bit_q   <= 4'd1;
            st_q    <= READ;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hdmi_ddc_edid_slave.sv
// tb_hdmi_ddc_edid_slave: bit-banged DDC master with a scoreboard of expected EDID bytes for hdmi_ddc_edid_slave.
module tb_hdmi_ddc_edid_slave;
`ifdef DDC_SEGMENT_EN
  localparam int AW = 9;
`else
  localparam int AW = 8;
`endif
  localparam int Q = 10;
  logic clk = 1'b0, reset = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic sda_oen, busy, rd_strobe, bus_sda;
  logic [AW-1:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] rom [1<<AW];
  logic [7:0] exp_q[$], got_q[$];
  int checks = 0, errors = 0, low_cnt = 0;
  int m_off = 0, m_seg = 0;
  always #5 clk = ~clk;
  assign bus_sda = m_sda & sda_oen;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(negedge clk) if (!sda_oen) low_cnt++;
  hdmi_ddc_edid_slave #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .scl_i(m_scl), .sda_i(bus_sda), .sda_oen(sda_oen),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .rd_strobe(rd_strobe)
  );
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, g, e);
    end
  endtask
  always @(negedge clk)
    if (rd_strobe) begin
      if (exp_q.size() == 0 || got_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else chk("rd_byte", got_q.pop_front(), exp_q.pop_front());
    end
  task automatic wq;
    repeat (Q) @(negedge clk);
  endtask
  task automatic start_c;
    m_sda = 1'b1; wq; m_scl = 1'b1; wq; m_sda = 1'b0; wq; m_scl = 1'b0; wq;
  endtask
  task automatic stop_c;
    m_sda = 1'b0; wq; m_scl = 1'b1; wq; m_sda = 1'b1; wq; wq;
    m_seg = 0;
  endtask
  task automatic bit_io(input logic b, output logic r);
    m_sda = b; wq; m_scl = 1'b1; wq; r = bus_sda; wq; m_scl = 1'b0; wq;
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(input logic last);
    logic [7:0] d;
    logic r;
    exp_q.push_back(rom[m_seg * 256 + m_off]);
    m_off = (m_off + 1) % 256;
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wq; m_scl = 1'b1; wq;
      d[i] = bus_sda;
      if (i == 0) got_q.push_back(d);
      wq; m_scl = 1'b0; wq;
    end
    bit_io(last, r);
  endtask
  task automatic set_offset(input logic [7:0] off);
    logic a;
    start_c; wr_byte(8'hA0, a); chk("addr_w_ack", a, 1);
    wr_byte(off, a); chk("ofs_ack", a, 1);
    m_off = off;
  endtask
  task automatic txn_read(input logic set_off, input logic [7:0] off, input int n);
    logic a;
    if (set_off) set_offset(off);
    start_c; wr_byte(8'hA1, a); chk("addr_r_ack", a, 1);
    chk("busy_addressed", busy, 1);
    for (int i = 0; i < n; i++) rd_byte(i == n - 1);
    stop_c;
    chk("busy_after_stop", busy, 0);
  endtask
  task automatic txn_write(input logic [7:0] off, input int n);
    logic a;
    set_offset(off);
    for (int i = 0; i < n; i++) begin
      wr_byte(8'($urandom), a); chk("wdata_ack", a, 1);
      m_off = (m_off + 1) % 256;
    end
    stop_c;
  endtask
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    logic a;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h00; rom[7] = 8'h00;
    for (int i = 1; i < 7; i++) rom[i] = 8'hFF;
    if (AW > 8) rom[256] = 8'h5A;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_strobe", rd_strobe, 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    wq;
    // EDID header read with offset write and repeated START
    txn_read(1'b1, 8'h00, 8);
    // foreign address: must stay silent and not busy
    low_cnt = 0;
    start_c; wr_byte(8'hA2, a); chk("foreign_nack", a, 0);
    chk("foreign_busy", busy, 0);
    wr_byte(8'h00, a); chk("foreign_data_nack", a, 0);
    stop_c;
    chk("foreign_quiet", low_cnt, 0);
    // offset wrap, then current-address read
    txn_read(1'b1, 8'hFE, 3);
    txn_read(1'b0, 8'h00, 1);
`ifdef DDC_SEGMENT_EN
    start_c; wr_byte(8'h60, a); chk("seg_ack", a, 1);
    wr_byte(8'h01, a); chk("seg_val_ack", a, 1);
    m_seg = 1;
    set_offset(8'h00);
    start_c; wr_byte(8'hA1, a); chk("seg_rd_ack", a, 1);
    rd_byte(1'b1);
    stop_c;
    txn_read(1'b1, 8'h00, 1);
    start_c; wr_byte(8'h61, a); chk("seg_read_nack", a, 0);
    stop_c;
`else
    start_c; wr_byte(8'h60, a); chk("seg_foreign_nack", a, 0);
    stop_c;
`endif
    for (int t = 0; t < 6; t++)
      if ($urandom_range(0, 3) == 0) txn_write(8'($urandom), $urandom_range(1, 3));
      else txn_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 4));
    // reset in the middle of a byte whose bits are all driven low
    set_offset(8'h00);
    start_c; wr_byte(8'hA1, a); chk("abort_addr_ack", a, 1);
    for (int i = 7; i >= 4; i--) begin
      m_sda = 1'b1; wq; m_scl = 1'b1; wq;
      if (i > 4) begin wq; m_scl = 1'b0; wq; end
    end
    chk("abort_driving", sda_oen, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_released", sda_oen, 1);
    chk("abort_busy", busy, 0);
    m_off = 0;
    m_seg = 0;
    wq; m_scl = 1'b0; wq;
    stop_c;
    txn_read(1'b0, 8'h00, 2);
    txn_read(1'b1, 8'h05, 2);
    wq;
    chk("exp_drained", exp_q.size(), 0);
    chk("got_drained", got_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
